// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - funct3 width codes for loads and stores
//   - FSM state encodings (IDLE / BUSY / DONE)
//   - byte-enable base patterns for byte, halfword and word accesses
//   - access-size decode helper (undefined codes decode as word)
// ---------------------------------------------------------------------------
package lsu_pkg;

    // funct3 width codes; stores use the B/H/W codes only
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Byte-enable patterns before lane shifting
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_e;

    // 011, 110 and 111 fall through to word
    function automatic lsu_size_e size_of(input logic [2:0] f3);
        lsu_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_BYTE;
            F3_H, F3_HU: sz = SZ_HALF;
            default:     sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational lane steering for the load/store unit.
// Store side: replicates store data across the word and builds byte enables
// from the access size and the low address bits.
// Load side: selects the addressed byte/halfword from the returned bus word
// and sign- or zero-extends it (funct3[2] = 1 selects zero extension).
// Ports:
//   i_st_funct3  in  3   width code of the access being issued
//   i_st_off     in  2   low address bits of the access being issued
//   i_st_data    in  32  raw store data
//   o_be         out 4   byte enables
//   o_wdata      out 32  lane-replicated store data
//   i_ld_funct3  in  3   width code of the load in flight
//   i_ld_off     in  2   low address bits of the load in flight
//   i_rdata      in  32  word returned by the bus
//   o_ld_data    out 32  extended load result
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_zext;

    // Store lane replication and byte enables
    always_comb begin
        o_be    = BE_WORD;
        o_wdata = i_st_data;
        case (size_of(i_st_funct3))
            SZ_BYTE: begin
                o_be    = BE_BYTE << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                // a[0] is ignored here; misalignment is handled by the top
                o_be    = BE_HALF << {i_st_off[1], 1'b0};
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                o_be    = BE_WORD;
                o_wdata = i_st_data;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        w_zext = i_ld_funct3[2];
        case (i_ld_off)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (size_of(i_ld_funct3))
            SZ_BYTE: o_ld_data = {{24{w_byte[7] & ~w_zext}}, w_byte};
            SZ_HALF: o_ld_data = {{16{w_half[15] & ~w_zext}}, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store unit. Issues one access at a time on a valid/ack
// data bus, returns lane-aligned, extended load data, and freezes the
// pipeline (Stall_LSU) while an access is in flight.
// FSM: IDLE -> BUSY (bus_req high until ack or timeout) -> DONE (1 cycle).
// Optional feature, macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word
// accesses skip the bus, go IDLE -> DONE and pulse misalign_err. Without it
// misalign_err is tied low and the alignment bits are ignored.
// Ports:
//   clk, reset               clock (rising edge), synchronous active-high reset
//   MemReadM, MemWriteM      M-stage load / store request (both = store)
//   funct3M                  access width code
//   ALUResultM               byte address
//   WriteDataM               store data (low bits significant)
//   ReadDataM                extended load data, held until the next load
//   Stall_LSU                pipeline freeze request (combinational)
//   bus_req/we/addr/wdata/be registered bus request
//   bus_ack, bus_rdata       bus completion and read word
//   lsu_err                  one-cycle pulse in DONE after a bus timeout
//   misalign_err             one-cycle pulse in DONE after a trapped access
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        Stall_LSU,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        lsu_err,
    output logic        misalign_err
);

    // Counter value on the last BUSY cycle that may still accept an ack
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_load;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;

    logic             w_access;
    logic             w_trap;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ld_data;

    assign w_access = MemReadM | MemWriteM;

`ifdef LSU_MISALIGN_TRAP_EN
    lsu_size_e w_size;
    assign w_size = size_of(funct3M);
    assign w_trap = ((w_size == SZ_HALF) & ALUResultM[0])
                  | ((w_size == SZ_WORD) & (|ALUResultM[1:0]));
`else
    assign w_trap = 1'b0;
`endif

    assign Stall_LSU = ((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY);

    lsu_align u_align (
        .i_st_funct3 (funct3M),
        .i_st_off    (ALUResultM[1:0]),
        .i_st_data   (WriteDataM),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_rdata     (bus_rdata),
        .o_ld_data   (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_is_load    <= 1'b0;
            r_funct3     <= 3'b000;
            r_off        <= 2'b00;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_wdata    <= 32'h0;
            bus_be       <= 4'h0;
            ReadDataM    <= 32'h0;
            lsu_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses visible in DONE
            lsu_err      <= 1'b0;
            misalign_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        if (w_trap) begin
                            misalign_err <= 1'b1;
                            if (!MemWriteM) begin
                                ReadDataM <= 32'h0;
                            end
                            r_state <= ST_DONE;
                        end else begin
                            bus_req   <= 1'b1;
                            bus_we    <= MemWriteM;
                            bus_addr  <= {ALUResultM[31:2], 2'b00};
                            bus_wdata <= w_wdata;
                            bus_be    <= w_be;
                            r_is_load <= ~MemWriteM;
                            r_funct3  <= funct3M;
                            r_off     <= ALUResultM[1:0];
                            r_cnt     <= '0;
                            r_state   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // An ack on the last allowed cycle still wins over timeout
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (r_is_load) begin
                            ReadDataM <= w_ld_data;
                        end
                        r_state <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        bus_req <= 1'b0;
                        lsu_err <= 1'b1;
                        if (r_is_load) begin
                            ReadDataM <= 32'h0;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage load/store unit directly downstream of the pipelined datapath.
- Consumes ALUResultM (address), WriteDataM, the M-stage memory controls and funct3M. Drives a single-outstanding valid/ack data bus.
- Returns lane-aligned, sign- or zero-extended load data as ReadDataM.
- Asserts Stall_LSU to the hazard unit, which freezes F/D/E/M while an access is in flight.

Parameters:
- MAX_WAIT, 16: BUSY cycles allowed without bus_ack before a timeout error.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- MemReadM  in  1  M-stage load request
- MemWriteM  in  1  M-stage store request
- funct3M  in  3  width code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores 000 SB, 001 SH, 010 SW
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data; low bits are significant
- ReadDataM  out  32  extended load data, to the datapath
- Stall_LSU  out  1  pipeline freeze request
- bus_req  out  1  bus request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, with bits [1:0] = 00
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ack  in  1  bus completion, valid only while bus_req = 1
- bus_rdata  in  32  read word, valid with bus_ack
- lsu_err  out  1  one-cycle pulse on bus timeout
- misalign_err  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Reset, synchronous and active-high: state = IDLE, wait counter = 0. All registered outputs (bus_req, bus_we, bus_addr, bus_wdata, bus_be, ReadDataM, lsu_err, misalign_err) are 0.
- Reset asserted mid-access drops bus_req at the next edge; any later bus_ack is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access = MemReadM | MemWriteM. If both are set, the access is a write.
  - On access, the bus outputs are registered at this edge and the FSM moves to BUSY.
  - bus_req is high from the next cycle.
- BUSY:
  - bus_req, bus_we, bus_addr, bus_wdata and bus_be are held stable until bus_ack.
  - The wait counter increments each BUSY cycle.
  - On bus_ack: a load captures the extended data into ReadDataM; bus_req drops at the edge; the FSM moves to DONE.
  - If the counter reaches MAX_WAIT with no ack: bus_req drops, ReadDataM = 0, lsu_err pulses in DONE, and the FSM moves to DONE.
- DONE: lasts one cycle, then IDLE unconditionally. The pipeline advances at the end of this cycle.
- Stall_LSU is combinational: (IDLE & access) | BUSY. It is low in DONE.
- Minimum access latency is 3 cycles (IDLE, BUSY with same-cycle ack, DONE), i.e. 2 stall cycles.
- bus_ack outside BUSY is ignored.
- ReadDataM holds its value until the next load completes. Stores leave it unchanged.
- Store lane steering:
  - SB: be = 0001 << a[1:0], wdata = {4{WriteDataM[7:0]}}.
  - SH: be = 0011 << {a[1],0}, wdata = {2{WriteDataM[15:0]}}.
  - SW: be = 1111.
- Load lane steering:
  - sh = rdata >> 8*a[1:0] for bytes, rdata >> 16*a[1] for halves.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Loads drive be with the same pattern as stores.
- Undefined funct3 codes (011, 110, 111) are treated as word accesses.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with a[0] = 1, or a word with a[1:0] != 00, issues no bus request.
  - The FSM goes IDLE -> DONE directly (1 stall cycle).
  - misalign_err pulses in DONE; a load returns ReadDataM = 0.
- Undefined:
  - misalign_err is tied 0.
  - Alignment bits are ignored: halfword uses a[1] only, word uses no low bits.
  - The access proceeds normally.

Decomposition:
- Package lsu_pkg holds:
  - funct3 width encodings
  - FSM state enum (IDLE/BUSY/DONE)
  - byte-enable base patterns
- Sub-module lsu_align: combinational store lane replication/byte enables and load extraction/extension, instantiated once.

Test Plan:
- SW at 0x100, data 0xDEADBEEF, ack on the first BUSY cycle -> bus_addr = 0x100, be = 1111, wdata = 0xDEADBEEF; Stall_LSU high for 2 cycles, low in DONE.
- LB at 0x103 with rdata 0x80FF0011 -> be = 1000, ReadDataM = 0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LH at 0x102 with rdata 0x8001_1234 -> ReadDataM = 0xFFFF8001. Repeat as LHU -> 0x00008001.
- Load with no ack for MAX_WAIT = 16 cycles -> bus_req drops, lsu_err pulses once, ReadDataM = 0, pipeline resumes.
- Reset asserted in BUSY, followed by a late bus_ack -> bus_req = 0 after the edge, ack ignored, state IDLE, no capture.
- With LSU_MISALIGN_TRAP_EN defined, LW at 0x101 -> no bus_req, 1 stall cycle, misalign_err pulses once. Without the macro -> bus_addr = 0x100, be = 1111.
